// File: rtl/aes_128_pipe.sv
// rtl/aes_128_pipe.sv - fully pipelined AES-128 encryptor, one round per stage, one block per clock
module aes_128_pipe_sbox (
    input  logic [7:0] value,
    output logic [7:0] sub
);
    localparam logic [0:255][7:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign sub = TABLE[value];
endmodule

module aes_128_pipe (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out
);
    localparam logic [1:10][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic [9:0][127:0]  s_q;
    logic [9:0][127:0]  k_q;
    logic [9:0]         fill;
    logic [10:1][127:0] sub_bytes;
    logic [10:1][127:0] round_key;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte r+4c of the result comes from row r, column (c+r) mod 4 of the input.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return t;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] m;
        for (int c = 0; c < 4; c++)
            m[127-32*c -: 32] = mix_column(s[127-32*c -: 32]);
        return m;
    endfunction

    for (genvar r = 1; r <= 10; r++) begin : g_round
        logic [31:0] rot_word, sub_word, t, w0, w1, w2, w3;

        for (genvar i = 0; i < 16; i++) begin : g_data_sbox
            aes_128_pipe_sbox u_sbox (
                .value (s_q[r-1][127-8*i -: 8]),
                .sub   (sub_bytes[r][127-8*i -: 8])
            );
        end

        assign rot_word = {k_q[r-1][23:0], k_q[r-1][31:24]};
        for (genvar i = 0; i < 4; i++) begin : g_key_sbox
            aes_128_pipe_sbox u_sbox (
                .value (rot_word[31-8*i -: 8]),
                .sub   (sub_word[31-8*i -: 8])
            );
        end

        assign t  = sub_word ^ {RCON[r], 24'h000000};
        assign w0 = k_q[r-1][127:96] ^ t;
        assign w1 = k_q[r-1][95:64]  ^ w0;
        assign w2 = k_q[r-1][63:32]  ^ w1;
        assign w3 = k_q[r-1][31:0]   ^ w2;
        assign round_key[r] = {w0, w1, w2, w3};
    end

    // fill[k] marks that stage k holds a block sampled after the last reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q  <= '0;
            k_q  <= '0;
            fill <= '0;
            out  <= '0;
        end else begin
            s_q[0] <= state ^ key;
            k_q[0] <= key;
            for (int r = 1; r <= 9; r++) begin
                s_q[r] <= mix_columns(shift_rows(sub_bytes[r])) ^ round_key[r];
                k_q[r] <= round_key[r];
            end
            fill <= {fill[8:0], 1'b1};
            out  <= fill[9] ? (shift_rows(sub_bytes[10]) ^ round_key[10]) : '0;
        end
    end
endmodule

// File: tb/tb_aes_128_pipe.sv
// tb/tb_aes_128_pipe.sv - self-checking bench for aes_128_pipe against a byte-level AES model
module tb_aes_128_pipe;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] state, key, out_w;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [7:0]   sbox_m [256];

    aes_128_pipe dut (.clk(clk), .rst(rst), .state(state), .key(key), .out(out_w));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    task automatic build_sbox();
        logic [7:0] inv, y;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[x] = y;
        end
    endtask

    function automatic logic [127:0] model_encrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h000000};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int b = 0; b < 16; b++) s[b] = pt[127-8*b -: 8] ^ w[b/4][31-8*(b%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int b = 0; b < 16; b++) s[b] = sbox_m[s[b]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = (rnd == 10) ? t[4*c+r] :
                               gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                               ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
            for (int b = 0; b < 16; b++) s[b] = s[b] ^ w[4*rnd + b/4][31-8*(b%4) -: 8];
        end
        for (int b = 0; b < 16; b++) res[127-8*b -: 8] = s[b];
        return res;
    endfunction

    task automatic test_reset();
        rst = 1'b1; state = PT_B; key = KEY_B;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (out_w !== 128'h0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %h want 0", i, out_w);
            end
        end
        rst = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            n_cmp++;
            if (out_w !== 128'h0) begin
                n_bad++;
                $display("FAIL reset_fill[N+%0d]: got %h want 0", e, out_w);
            end
        end
        step();
        n_cmp++;
        if (out_w !== CT_B) begin
            n_bad++;
            $display("FAIL reset_first_out: got %h want %h", out_w, CT_B);
        end
    endtask

    task automatic test_known_vectors();
        logic [127:0] pts [3] = '{PT_B, PT_C, 128'h0};
        logic [127:0] keys[3] = '{KEY_B, KEY_C, 128'h0};
        logic [127:0] cts [3] = '{CT_B, CT_C, CT_Z};
        for (int v = 0; v < 3; v++) begin
            state = pts[v]; key = keys[v];
            n_cmp++;
            if (model_encrypt(pts[v], keys[v]) !== cts[v]) begin
                n_bad++;
                $display("FAIL model_vec[%0d]: got %h want %h", v, model_encrypt(pts[v], keys[v]), cts[v]);
            end
            repeat (11) step();
            n_cmp++;
            if (out_w !== cts[v]) begin
                n_bad++;
                $display("FAIL known_vec[%0d]: got %h want %h", v, out_w, cts[v]);
            end
        end
    endtask

    task automatic test_back_to_back();
        state = PT_B; key = KEY_B; step();
        state = PT_C; key = KEY_C; step();
        state = '0;   key = '0;    step();
        repeat (7) step();
        step();
        n_cmp++;
        if (out_w !== CT_B) begin n_bad++; $display("FAIL b2b_0: got %h want %h", out_w, CT_B); end
        step();
        n_cmp++;
        if (out_w !== CT_C) begin n_bad++; $display("FAIL b2b_1: got %h want %h", out_w, CT_C); end
        step();
        n_cmp++;
        if (out_w !== CT_Z) begin n_bad++; $display("FAIL b2b_2: got %h want %h", out_w, CT_Z); end
    endtask

    task automatic test_latency();
        logic [127:0] new_pt, exp_new;
        state = PT_B; key = KEY_B;
        repeat (11) step();
        new_pt  = {$urandom, $urandom, $urandom, $urandom};
        exp_new = model_encrypt(new_pt, KEY_B);
        state   = new_pt;
        for (int e = 0; e < 10; e++) begin
            step();
            n_cmp++;
            if (out_w !== CT_B) begin
                n_bad++;
                $display("FAIL latency_early[M+%0d]: got %h want %h", e, out_w, CT_B);
            end
        end
        step();
        n_cmp++;
        if (out_w !== exp_new) begin
            n_bad++;
            $display("FAIL latency_edge10: got %h want %h", out_w, exp_new);
        end
    endtask

    task automatic test_random_stream();
        logic [127:0] exp_q [$];
        logic [127:0] exp_v;
        exp_q = {};
        for (int i = 0; i < 60; i++) begin
            state = {$urandom, $urandom, $urandom, $urandom};
            key   = (i % 7 == 0) ? KEY_C : {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(model_encrypt(state, key));
            step();
            if (exp_q.size() == 11) begin
                exp_v = exp_q.pop_front();
                n_cmp++;
                if (out_w !== exp_v) begin
                    n_bad++;
                    $display("FAIL random[%0d]: got %h want %h", i, out_w, exp_v);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [127:0] exp_v;
        for (int i = 0; i < 5; i++) begin
            state = {$urandom, $urandom, $urandom, $urandom};
            key   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (out_w !== 128'h0) begin
                n_bad++;
                $display("FAIL midreset_hold[%0d]: got %h want 0", i, out_w);
            end
        end
        rst   = 1'b0;
        state = {$urandom, $urandom, $urandom, $urandom};
        key   = {$urandom, $urandom, $urandom, $urandom};
        exp_v = model_encrypt(state, key);
        for (int e = 0; e < 10; e++) begin
            step();
            n_cmp++;
            if (out_w !== 128'h0) begin
                n_bad++;
                $display("FAIL midreset_fill[N+%0d]: got %h want 0", e, out_w);
            end
        end
        step();
        n_cmp++;
        if (out_w !== exp_v) begin
            n_bad++;
            $display("FAIL midreset_out: got %h want %h", out_w, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; state = '0; key = '0;
        build_sbox();
        test_reset();
        test_known_vectors();
        test_back_to_back();
        test_latency();
        test_random_stream();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
